// File: rtl/div_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_seq_param : iterative radix-2 restoring divider, unsigned or signed    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module div_seq_param #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] number_A,
  input  logic [WIDTH-1:0] number_B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             overflow,
  output logic             busy,
  output logic             ready
);

  localparam int               c_CW       = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_ZERO  = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic             w_mode;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_signed, r_sign_q, r_sign_r, r_ovf;
  logic [WIDTH-1:0] r_dvd;   // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [c_CW-1:0]  r_cnt;

  generate
    if (SIGNED_EN) begin : g_signed
      assign w_mode = is_signed;
    end else begin : g_unsigned
      assign w_mode = 1'b0;
    end
  endgenerate

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_qbit;

  assign w_a_neg = r_signed & r_a[WIDTH-1];
  assign w_b_neg = r_signed & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~r_a + c_ONE) : r_a;
  assign w_b_mag = w_b_neg ? (~r_b + c_ONE) : r_b;

  // Borrow out of the (WIDTH+1)-bit trial subtraction means the divisor did not fit.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (number_B == '0) ? S_ZERO : S_SETUP;
      S_SETUP: w_next = S_RUN;
      S_RUN:   if (r_cnt == c_CNT_ONE) w_next = S_FIXUP;
      S_FIXUP: w_next = S_IDLE;
      S_ZERO:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_ovf     <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= number_A;
            r_b      <= number_B;
            r_signed <= w_mode;
            error    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SETUP: begin
          r_dvd    <= w_a_mag;
          r_dvs    <= w_b_mag;
          r_rem    <= '0;
          r_cnt    <= c_CNT_INIT;
          r_sign_q <= w_a_neg ^ w_b_neg;
          r_sign_r <= w_a_neg;
          r_ovf    <= r_signed && (r_a == c_MIN) && (r_b == '1);
        end
        S_RUN: begin
          r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - c_CNT_ONE;
        end
        S_FIXUP: begin
          // MIN/-1 falls out naturally: magnitude quotient 2^(WIDTH-1), sign_q=0.
          quotient  <= r_sign_q ? (~r_dvd + c_ONE) : r_dvd;
          remainder <= r_sign_r ? (~r_rem + c_ONE) : r_rem;
          overflow  <= r_ovf;
          ready     <= 1'b1;
          busy      <= 1'b0;
        end
        S_ZERO: begin
          quotient  <= '1;
          remainder <= r_a;
          error     <= 1'b1;
          ready     <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_seq_param : directed vectors for div_seq_param at WIDTH 32 and 8    |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sgn32, start8, sgn8;
  logic [31:0] a32, b32, q32, r32;
  logic [7:0]  a8, b8, q8, r8;
  logic        err32, ovf32, busy32, rdy32;
  logic        err8, ovf8, busy8, rdy8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .number_A(a32), .number_B(b32), .quotient(q32), .remainder(r32),
    .error(err32), .overflow(ovf32), .busy(busy32), .ready(rdy32)
  );

  div_seq_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .number_A(a8), .number_B(b8), .quotient(q8), .remainder(r8),
    .error(err8), .overflow(ovf8), .busy(busy8), .ready(rdy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts. Operands are scrambled afterwards.
  task automatic launch32(input logic [31:0] a, input logic [31:0] b, input logic s);
    start32 = 1'b1; a32 = a; b32 = b; sgn32 = s;
    @(negedge clk);
    start32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0; sgn32 = ~s;
    chk("busy_after_accept", {63'b0, busy32}, 64'd1);
    chk("ready_low_after_accept", {63'b0, rdy32}, 64'd0);
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (!rdy32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rdy32) chk("timeout32", {63'b0, rdy32}, 64'd1);
    chk("busy_low_at_ready", {63'b0, busy32}, 64'd0);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] eq, input logic [31:0] er, input logic ee,
                      input logic eo, input int elat);
    int lat;
    launch32(a, b, s);
    wait32(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_q"}, {32'b0, q32}, {32'b0, eq});
    chk({tag, "_r"}, {32'b0, r32}, {32'b0, er});
    chk({tag, "_err"}, {63'b0, err32}, {63'b0, ee});
    chk({tag, "_ovf"}, {63'b0, ovf32}, {63'b0, eo});
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", {32'b0, q32}, 64'd0);
    chk("reset_flags", {60'b0, err32, ovf32, busy32, rdy32}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back chain: each launch happens in the previous op's ready cycle.
    op32("u10d3",   32'd10,         32'd3,          1'b0, 32'd3,         32'd1,         1'b0, 1'b0, 34);
    op32("sm7d2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    op32("s7dm2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b0, 34);
    op32("sm7dm2",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    op32("u1250d0", 32'd1250,       32'd0,          1'b0, 32'hFFFF_FFFF, 32'd1250,      1'b1, 1'b0, 1);
    op32("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 34);
    op32("u_minm1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,         32'h8000_0000, 1'b0, 1'b0, 34);
    @(negedge clk);
    chk("ready_one_cycle", {63'b0, rdy32}, 64'd0);
    chk("q_held_idle", {32'b0, q32}, 64'd0);
    chk("r_held_idle", {32'b0, r32}, 64'h8000_0000);

    // WIDTH=8: a start pulse mid-run must not disturb the op in flight.
    start8 = 1'b1; a8 = 8'd255; b8 = 8'd1; sgn8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd2;
    @(negedge clk); lat++;
    start8 = 1'b0;
    chk("w8_busy_mid", {63'b0, busy8}, 64'd1);
    while (!rdy8 && lat < 100) begin @(negedge clk); lat++; end
    chk("w8_lat", 64'(lat), 64'd10);
    chk("w8_q", {56'b0, q8}, 64'd255);
    chk("w8_r", {56'b0, r8}, 64'd0);
    @(negedge clk);
    chk("w8_not_reaccepted", {62'b0, busy8, rdy8}, 64'd0);

    // WIDTH=8 signed: -100/7 -> -14 rem -2
    start8 = 1'b1; a8 = 8'h9C; b8 = 8'd7; sgn8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!rdy8 && lat < 100) begin @(negedge clk); lat++; end
    chk("w8s_q", {56'b0, q8}, 64'hF2);
    chk("w8s_r", {56'b0, r8}, 64'hFE);

    // Abort by reset in the middle of RUN.
    @(negedge clk);
    launch32(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_r", {32'b0, r32}, 64'd0);
    chk("abort_flags", {60'b0, err32, ovf32, busy32, rdy32}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (rdy32) pulses++;
    end
    chk("no_ready_after_abort", 64'(pulses), 64'd0);
    op32("u864d24", 32'd864, 32'd24, 1'b0, 32'd36, 32'd0, 1'b0, 1'b0, 34);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
